// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer: word-width helper, stream FSM states
// and the rounding/saturating requantizer reused by other layers.
package fc_pkg;

    typedef enum logic [0:0] {
        IDLE,
        STREAM
    } fc_state_e;

    function automatic int fc_in_w(input int width, input int fan_in);
        return width * 2 + $clog2(fan_in);
    endfunction

    // Round half up by adding 2^(shift-1) before the shift, then clamp to the largest
    // positive signed width-bit value; 64-bit arithmetic keeps the add from overflowing.
    function automatic logic [63:0] rq(input logic [63:0] v, input int shift, input int width);
        logic [63:0] t;
        logic [63:0] sat;
        t   = (v + ((shift > 0) ? (64'd1 << (shift - 1)) : 64'd0)) >> shift;
        sat = (64'd1 << (width - 1)) - 64'd1;
        return (t > sat) ? sat : t;
    endfunction

endpackage

// File: rtl/fc_requant.sv
// Combinational requantizer: one IN_W-bit neuron word to a saturated WIDTH-bit activation.
module fc_requant
    import fc_pkg::*;
#(
    parameter int IN_W  = 23,
    parameter int WIDTH = 8,
    parameter int SHIFT = 7
) (
    input  logic [IN_W-1:0]  i_word,
    output logic [WIDTH-1:0] o_q
);

    assign o_q = WIDTH'(rq(64'(i_word), SHIFT, WIDTH));

endmodule

// File: rtl/fc_requant_stream.sv
// Captures a vector of ReLU neuron outputs and streams requantized activations over valid/ready.
// Optional argmax output enabled by defining FC_ARGMAX_EN.
module fc_requant_stream
    import fc_pkg::*;
#(
    parameter int  WIDTH   = 8,
    parameter int  IN      = 128,
    parameter int  NEURONS = 10,
    parameter int  SHIFT   = 7,
    localparam int IN_W    = fc_in_w(WIDTH, IN),
    localparam int IDX_W   = $clog2(NEURONS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data [0:NEURONS-1],
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
`ifdef FC_ARGMAX_EN
    ,
    output logic [IDX_W-1:0] argmax_idx,
    output logic             argmax_valid
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

    fc_state_e        r_state;
    logic [IN_W-1:0]  r_buf [0:NEURONS-1];
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_out_valid;
    logic             r_in_ready;

    logic             w_xfer;
    logic             w_at_last;
    logic [IDX_W-1:0] w_next_idx;
    logic [IN_W-1:0]  w_word;
    logic [WIDTH-1:0] w_q;

    assign w_xfer     = r_out_valid && out_ready;
    assign w_at_last  = (r_idx == LAST_IDX);
    assign w_next_idx = w_at_last ? '0 : r_idx + 1'b1;

    // Requantize the word presented after the coming edge: element 0 of the arriving
    // vector while idle, otherwise the next buffered element.
    assign w_word = (r_state == IDLE) ? in_data[0] : r_buf[w_next_idx];

    fc_requant #(
        .IN_W  (IN_W),
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_requant (
        .i_word (w_word),
        .o_q    (w_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            // NOTE: the capture buffer is flops, not RAM, so clearing it on reset is cheap and keeps reset state fully defined.
            for (int i = 0; i < NEURONS; i++) r_buf[i] <= '0;
        end else begin
            // NOTE: all state uses <= so every register sees pre-edge values regardless of statement order.
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NEURONS; i++) r_buf[i] <= in_data[i];
                        r_idx       <= '0;
                        r_out_data  <= w_q;
                        r_out_last  <= (LAST_IDX == '0);
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                        r_state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_xfer) begin
                        if (w_at_last) begin
                            r_idx       <= '0;
                            r_out_data  <= '0;
                            r_out_last  <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_idx      <= w_next_idx;
                            r_out_data <= w_q;
                            r_out_last <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_out_data;
    assign out_idx   = r_idx;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

`ifdef FC_ARGMAX_EN
    logic [IN_W-1:0]  r_max_val;
    logic [IDX_W-1:0] r_max_idx;
    logic [IDX_W-1:0] r_argmax_idx;
    logic             r_argmax_valid;
    logic             w_beat_wins;
    logic [IDX_W-1:0] w_run_idx;

    // Strict greater-than keeps the earliest index on ties.
    assign w_beat_wins = (r_idx == '0) || (r_buf[r_idx] > r_max_val);
    assign w_run_idx   = w_beat_wins ? r_idx : r_max_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max_val      <= '0;
            r_max_idx      <= '0;
            r_argmax_idx   <= '0;
            r_argmax_valid <= 1'b0;
        end else begin
            r_argmax_valid <= 1'b0;
            if (w_xfer) begin
                if (w_beat_wins) r_max_val <= r_buf[r_idx];
                r_max_idx <= w_run_idx;
                if (w_at_last) begin
                    r_argmax_idx   <= w_run_idx;
                    r_argmax_valid <= 1'b1;
                end
            end
        end
    end

    assign argmax_idx   = r_argmax_idx;
    assign argmax_valid = r_argmax_valid;
`endif

endmodule

// File: tb/tb_fc_requant_stream.sv
// Randomized self-checking bench for fc_requant_stream against a behavioural model.
// Argmax checks are compiled in when FC_ARGMAX_EN is defined.
module tb_fc_requant_stream;

    localparam int WIDTH   = 8;
    localparam int IN      = 128;
    localparam int NEURONS = 10;
    localparam int SHIFT   = 7;
    localparam int IN_W    = 23;
    localparam int IDX_W   = 4;

    logic             clk;
    logic             rst;
    logic [IN_W-1:0]  in_data [NEURONS];
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
`ifdef FC_ARGMAX_EN
    logic [IDX_W-1:0] argmax_idx;
    logic             argmax_valid;
`endif

    logic [IN_W-1:0]  vec [NEURONS];
    int               n_checks;
    int               n_fail;

    fc_requant_stream #(
        .WIDTH   (WIDTH),
        .IN      (IN),
        .NEURONS (NEURONS),
        .SHIFT   (SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FC_ARGMAX_EN
        ,
        .argmax_idx   (argmax_idx),
        .argmax_valid (argmax_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-half-up division by 2^SHIFT via quotient/remainder, then clamp.
    function automatic longint model_rq(input longint v);
        longint d, q, r, lim;
        d   = longint'(1) << SHIFT;
        q   = v / d;
        r   = v % d;
        if (2 * r >= d) q = q + 1;
        lim = (longint'(1) << (WIDTH - 1)) - 1;
        return (q > lim) ? lim : q;
    endfunction

    function automatic int model_argmax(input logic [IN_W-1:0] v [NEURONS]);
        int best;
        best = 0;
        for (int i = 1; i < NEURONS; i++) if (v[i] > v[best]) best = i;
        return best;
    endfunction

    task automatic rand_vec();
        for (int i = 0; i < NEURONS; i++)
            vec[i] = ($urandom_range(0, 1) == 1) ? IN_W'($urandom_range(0, 20000))
                                                : {1'b0, 22'($urandom)};
    endtask

    task automatic wait_ready();
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("in_ready_idle", in_ready, 1);
    endtask

    // ready_mode: 0 always ready, 1 fixed 1,0,0,1,0,1 pattern, 2 random.
    task automatic run_vector(input int ready_mode, input bit stomp);
        logic [IN_W-1:0] cap [NEURONS];
        longint          exp_q [NEURONS];
        logic [0:5]      pat_bits;
        int              k, cyc, am;
        logic            r;
        cap      = vec;
        pat_bits = 6'b100101;
        for (int i = 0; i < NEURONS; i++) exp_q[i] = model_rq(longint'(cap[i]));
        am = model_argmax(cap);
        wait_ready();
        in_data  = cap;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = stomp;
        k   = 0;
        cyc = 0;
        while (k < NEURONS && cyc < 400) begin
            check("out_valid", out_valid, 1);
            check("in_ready_busy", in_ready, 0);
            check("out_data", out_data, exp_q[k]);
            check("out_idx", out_idx, k);
            check("out_last", out_last, (k == NEURONS - 1));
            if (stomp) for (int i = 0; i < NEURONS; i++) in_data[i] = {1'b0, 22'($urandom)};
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = pat_bits[cyc % 6];
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            @(negedge clk);
            if (r) k++;
            cyc++;
        end
        if (k < NEURONS) check("stream_timeout", k, NEURONS);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("out_valid_after", out_valid, 0);
        check("in_ready_after", in_ready, 1);
`ifdef FC_ARGMAX_EN
        check("argmax_pulse", argmax_valid, 1);
        check("argmax_idx", argmax_idx, am);
        @(negedge clk);
        check("argmax_pulse_end", argmax_valid, 0);
        check("argmax_hold", argmax_idx, am);
`else
        if (am < 0) check("argmax_model", am, 0);
`endif
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_idx"}, out_idx, 0);
        check({tag, "_out_last"}, out_last, 0);
`ifdef FC_ARGMAX_EN
        check({tag, "_argmax_idx"}, argmax_idx, 0);
        check({tag, "_argmax_valid"}, argmax_valid, 0);
`endif
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NEURONS; i++) in_data[i] = '0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Ramp i*256 with downstream always ready: expect 0,2,...,18.
        for (int i = 0; i < NEURONS; i++) vec[i] = IN_W'(i * 256);
        run_vector(0, 1'b0);

        // Rounding and saturation corners.
        vec = '{23'd63, 23'd64, 23'd191, 23'd192, 23'd16256, 23'd16320,
                23'h3FFFFF, 23'd0, 23'd16319, 23'd128};
        run_vector(0, 1'b0);

        // Fixed backpressure pattern.
        rand_vec();
        run_vector(1, 1'b0);

        // in_valid held high with changing in_data during the stream.
        rand_vec();
        run_vector(2, 1'b1);

        // Asynchronous reset in the middle of a vector.
        rand_vec();
        wait_ready();
        in_data  = vec;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_rst_idx", out_idx, 4);
        check("pre_rst_valid", out_valid, 1);
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        rand_vec();
        run_vector(1, 1'b0);

        // Tie on the maximum must resolve to the lowest index.
        vec = '{23'd5, 23'd900, 23'd3, 23'd900, 23'd1, 23'd2, 23'd899, 23'd0, 23'd900, 23'd4};
        run_vector(2, 1'b0);

        for (int n = 0; n < 15; n++) begin
            rand_vec();
            run_vector(2, n[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
